// File: rtl/hp48_bus_ram.sv
// Nibble-wide RAM peripheral for the HP48 Saturn bus: daisy-chained CONFIGURE,
// windowed PC/DP access with physical-size mirroring, optional read-only mode.
module hp48_bus_ram #(
  parameter int SIZE_LOG2 = 12,
  parameter bit READ_ONLY = 1'b0,
  parameter     ID_NAME   = "BUSRAM"
) (
  input  logic        strobe,
  input  logic        reset,
  input  logic [19:0] address,
  input  logic [3:0]  command,
  input  logic [3:0]  nibble_in,
  output logic [3:0]  nibble_out,
  output logic        active,
  input  logic        daisy_in,
  output logic        daisy_out,
  output logic        error
);

  localparam logic [3:0] CMD_NOP         = 4'h0;
  localparam logic [3:0] CMD_PC_READ     = 4'h2;
  localparam logic [3:0] CMD_DP_READ     = 4'h3;
  localparam logic [3:0] CMD_PC_WRITE    = 4'h4;
  localparam logic [3:0] CMD_DP_WRITE    = 4'h5;
  localparam logic [3:0] CMD_LOAD_PC     = 4'h6;
  localparam logic [3:0] CMD_LOAD_DP     = 4'h7;
  localparam logic [3:0] CMD_CONFIGURE   = 4'h8;
  localparam logic [3:0] CMD_UNCONFIGURE = 4'h9;
  localparam logic [3:0] CMD_BUS_RESET   = 4'hC;

  localparam int DEPTH = 1 << SIZE_LOG2;

  if (SIZE_LOG2 < 4 || SIZE_LOG2 > 20) begin : g_size_check
    $error("%s: SIZE_LOG2 must lie within 4..20", ID_NAME);
  end

  typedef enum logic [1:0] {
    ST_UNCONF  = 2'd0,
    ST_LEN_SET = 2'd1,
    ST_CONF    = 2'd2
  } cfg_state_t;

  cfg_state_t          state_r;
  cfg_state_t          state_nxt_s;
  logic [19:0]         pc_ptr_r;
  logic [19:0]         dp_ptr_r;
  logic [19:0]         base_r;
  logic [20:0]         length_r;
  logic [3:0]          nibble_out_r;
  logic                error_r;
  logic [3:0]          mem_r [0:DEPTH-1];

  logic                is_dp_s;
  logic                is_access_s;
  logic                is_write_s;
  logic [19:0]         ptr_sel_s;
  logic [20:0]         off_s;
  logic [20:0]         addr_off_s;
  logic                hit_s;
  logic                addr_hit_s;
  logic                configured_s;
  logic                active_s;
  logic                mem_we_s;
  logic [SIZE_LOG2-1:0] idx_s;

  // Access decode, window hit checks and physical index
  always_comb begin
    is_dp_s     = (command == CMD_DP_READ) || (command == CMD_DP_WRITE);
    is_write_s  = (command == CMD_PC_WRITE) || (command == CMD_DP_WRITE);
    is_access_s = is_write_s || (command == CMD_PC_READ) || (command == CMD_DP_READ);
    ptr_sel_s   = is_dp_s ? dp_ptr_r : pc_ptr_r;
    // 21-bit compare keeps a window ending exactly at 0x100000 from wrapping
    off_s       = {1'b0, ptr_sel_s} - {1'b0, base_r};
    addr_off_s  = {1'b0, address} - {1'b0, base_r};
    hit_s       = (ptr_sel_s >= base_r) && (off_s < length_r);
    addr_hit_s  = (address >= base_r) && (addr_off_s < length_r);
    configured_s = (state_r == ST_CONF);
    active_s    = configured_s && hit_s && is_access_s;
    mem_we_s    = active_s && is_write_s && !READ_ONLY && !reset;
    idx_s       = off_s[SIZE_LOG2-1:0];
  end

  // Configuration state register
  always_ff @(posedge strobe) begin
    if (reset) begin
      state_r <= ST_UNCONF;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Configuration next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (command)
      CMD_CONFIGURE: begin
        if (daisy_in) begin
          case (state_r)
            ST_UNCONF:  state_nxt_s = ST_LEN_SET;
            ST_LEN_SET: state_nxt_s = ST_CONF;
            default:    state_nxt_s = state_r;
          endcase
        end else begin
          state_nxt_s = state_r;
        end
      end
      CMD_UNCONFIGURE: begin
        if (configured_s && addr_hit_s) begin
          state_nxt_s = ST_UNCONF;
        end else begin
          state_nxt_s = state_r;
        end
      end
      CMD_BUS_RESET: state_nxt_s = ST_UNCONF;
      default:       state_nxt_s = state_r;
    endcase
  end

  // Pointers, window registers, read data and sticky error
  always_ff @(posedge strobe) begin
    if (reset) begin
      pc_ptr_r     <= 20'h00000;
      dp_ptr_r     <= 20'h00000;
      base_r       <= 20'h00000;
      length_r     <= 21'h000000;
      nibble_out_r <= 4'h0;
      error_r      <= 1'b0;
    end else begin
      case (command)
        CMD_NOP: ;
        CMD_PC_READ, CMD_DP_READ: begin
          if (active_s) nibble_out_r <= mem_r[idx_s];
          if (is_dp_s) dp_ptr_r <= dp_ptr_r + 20'd1;
          else         pc_ptr_r <= pc_ptr_r + 20'd1;
        end
        CMD_PC_WRITE, CMD_DP_WRITE: begin
          if (active_s && READ_ONLY) error_r <= 1'b1;
          if (is_dp_s) dp_ptr_r <= dp_ptr_r + 20'd1;
          else         pc_ptr_r <= pc_ptr_r + 20'd1;
        end
        CMD_LOAD_PC: pc_ptr_r <= address;
        CMD_LOAD_DP: dp_ptr_r <= address;
        CMD_CONFIGURE: begin
          if (daisy_in && state_r == ST_UNCONF) length_r <= 21'h100000 - {1'b0, address};
          if (daisy_in && state_r == ST_LEN_SET) base_r <= address;
        end
        CMD_UNCONFIGURE: begin
          if (configured_s && addr_hit_s) begin
            base_r   <= 20'h00000;
            length_r <= 21'h000000;
          end
        end
        CMD_BUS_RESET: begin
          base_r   <= 20'h00000;
          length_r <= 21'h000000;
        end
        default: error_r <= 1'b1;
      endcase
    end
  end

  // Memory array write port; contents survive reset
  always_ff @(posedge strobe) begin
    if (mem_we_s) begin
      mem_r[idx_s] <= nibble_in;
    end
  end

  assign nibble_out = nibble_out_r;
  assign error      = error_r;
  assign daisy_out  = configured_s;
  assign active     = active_s;

endmodule

// File: tb/tb_hp48_bus_ram.sv
// Directed bench for hp48_bus_ram: a default instance, a 16-nibble mirroring
// instance and a read-only instance, each on its own bus signals.
module tb_hp48_bus_ram;

  localparam logic [3:0] NOP = 4'h0, PC_READ = 4'h2, DP_READ = 4'h3, PC_WRITE = 4'h4,
                         DP_WRITE = 4'h5, LOAD_PC = 4'h6, LOAD_DP = 4'h7,
                         CONFIGURE = 4'h8, UNCONFIGURE = 4'h9, BUS_RESET = 4'hC,
                         UNDEFINED = 4'hF;

  logic        strobe = 1'b0;
  logic        reset;
  logic [19:0] adr [3];
  logic [3:0]  cmd [3];
  logic [3:0]  nin [3];
  logic        din [3];
  logic [3:0]  nout [3];
  logic        act [3];
  logic        dout [3];
  logic        err [3];

  logic        act_pre;
  logic [3:0]  old_nib;
  int          n_assert = 0;
  int          n_fail = 0;

  always #5 strobe = ~strobe;

  hp48_bus_ram u_ram (
    .strobe(strobe), .reset(reset), .address(adr[0]), .command(cmd[0]),
    .nibble_in(nin[0]), .nibble_out(nout[0]), .active(act[0]),
    .daisy_in(din[0]), .daisy_out(dout[0]), .error(err[0]));

  hp48_bus_ram #(.SIZE_LOG2(4)) u_mirror (
    .strobe(strobe), .reset(reset), .address(adr[1]), .command(cmd[1]),
    .nibble_in(nin[1]), .nibble_out(nout[1]), .active(act[1]),
    .daisy_in(din[1]), .daisy_out(dout[1]), .error(err[1]));

  hp48_bus_ram #(.READ_ONLY(1'b1)) u_ro (
    .strobe(strobe), .reset(reset), .address(adr[2]), .command(cmd[2]),
    .nibble_in(nin[2]), .nibble_out(nout[2]), .active(act[2]),
    .daisy_in(din[2]), .daisy_out(dout[2]), .error(err[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One bus cycle on unit u; active is sampled just before the edge
  task automatic cyc(input int u, input logic [3:0] c, input logic [19:0] a, input logic [3:0] n);
    for (int k = 0; k < 3; k++) cmd[k] = NOP;
    cmd[u] = c;
    adr[u] = a;
    nin[u] = n;
    #1;
    act_pre = act[u];
    @(posedge strobe);
    #1;
    cmd[u] = NOP;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      adr[k] = 20'h0; cmd[k] = NOP; nin[k] = 4'h0; din[k] = 1'b1;
    end
    din[0] = 1'b0;

    // Reset overriding a CONFIGURE on the same edge
    reset = 1'b1;
    cyc(0, CONFIGURE, 20'hFF000, 4'h0);
    check("rst_nibble", {28'h0, nout[0]}, 32'h0);
    check("rst_error", {31'h0, err[0]}, 32'h0);
    check("rst_daisy", {31'h0, dout[0]}, 32'h0);
    check("rst_length", {11'h0, u_ram.length_r}, 32'h0);
    check("rst_pc", {12'h0, u_ram.pc_ptr_r}, 32'h0);
    check("rst_dp", {12'h0, u_ram.dp_ptr_r}, 32'h0);
    reset = 1'b0;
    cyc(0, DP_READ, 20'h0, 4'h0);
    check("rst_active", {31'h0, act_pre}, 32'h0);

    // Daisy chain gating, then the two-step configure
    cyc(0, CONFIGURE, 20'hFF000, 4'h0);
    check("cfg_gated_daisy", {31'h0, dout[0]}, 32'h0);
    check("cfg_gated_len", {11'h0, u_ram.length_r}, 32'h0);
    check("cfg_gated_err", {31'h0, err[0]}, 32'h0);
    din[0] = 1'b1;
    cyc(0, CONFIGURE, 20'hFF000, 4'h0);
    check("cfg_len", {11'h0, u_ram.length_r}, 32'h1000);
    check("cfg_len_daisy", {31'h0, dout[0]}, 32'h0);
    cyc(0, CONFIGURE, 20'h70000, 4'h0);
    check("cfg_base", {12'h0, u_ram.base_r}, 32'h70000);
    check("cfg_daisy", {31'h0, dout[0]}, 32'h1);
    cyc(0, CONFIGURE, 20'h12345, 4'h0);
    check("cfg_extra_base", {12'h0, u_ram.base_r}, 32'h70000);
    check("cfg_extra_err", {31'h0, err[0]}, 32'h0);

    // Write/read round trip
    cyc(0, LOAD_DP, 20'h70010, 4'h0);
    cyc(0, DP_WRITE, 20'h0, 4'hA); check("wr_a_act", {31'h0, act_pre}, 32'h1);
    cyc(0, DP_WRITE, 20'h0, 4'hB); check("wr_b_act", {31'h0, act_pre}, 32'h1);
    cyc(0, DP_WRITE, 20'h0, 4'hC); check("wr_c_act", {31'h0, act_pre}, 32'h1);
    cyc(0, LOAD_DP, 20'h70010, 4'h0);
    cyc(0, DP_READ, 20'h0, 4'h0);
    check("rd_a_act", {31'h0, act_pre}, 32'h1);
    check("rd_a", {28'h0, nout[0]}, 32'hA);
    cyc(0, DP_READ, 20'h0, 4'h0); check("rd_b", {28'h0, nout[0]}, 32'hB);
    cyc(0, DP_READ, 20'h0, 4'h0); check("rd_c", {28'h0, nout[0]}, 32'hC);
    check("rd_dp_end", {12'h0, u_ram.dp_ptr_r}, 32'h70013);

    // Window edges
    cyc(0, LOAD_PC, 20'h70000, 4'h0);
    cyc(0, PC_WRITE, 20'h0, 4'h1);
    cyc(0, LOAD_PC, 20'h70FFF, 4'h0);
    cyc(0, PC_WRITE, 20'h0, 4'h9);
    check("edge_top_act", {31'h0, act_pre}, 32'h1);
    check("edge_top_pc", {12'h0, u_ram.pc_ptr_r}, 32'h71000);
    cyc(0, PC_WRITE, 20'h0, 4'h3);
    check("edge_above_act", {31'h0, act_pre}, 32'h0);
    check("edge_above_pc", {12'h0, u_ram.pc_ptr_r}, 32'h71001);
    cyc(0, LOAD_PC, 20'h6FFFF, 4'h0);
    cyc(0, PC_WRITE, 20'h0, 4'h3);
    check("edge_below_act", {31'h0, act_pre}, 32'h0);
    check("edge_below_pc", {12'h0, u_ram.pc_ptr_r}, 32'h70000);
    cyc(0, PC_READ, 20'h0, 4'h0);
    check("edge_mem_lo", {28'h0, nout[0]}, 32'h1);
    cyc(0, LOAD_PC, 20'h70FFF, 4'h0);
    cyc(0, PC_READ, 20'h0, 4'h0);
    check("edge_mem_hi", {28'h0, nout[0]}, 32'h9);
    cyc(0, LOAD_PC, 20'h71000, 4'h0);
    cyc(0, PC_READ, 20'h0, 4'h0);
    check("miss_rd_act", {31'h0, act_pre}, 32'h0);
    check("miss_rd_hold", {28'h0, nout[0]}, 32'h9);

    // Unconfigure, repeated unconfigure
    cyc(0, UNCONFIGURE, 20'h70500, 4'h0);
    check("unc_daisy", {31'h0, dout[0]}, 32'h0);
    check("unc_len", {11'h0, u_ram.length_r}, 32'h0);
    check("unc_base", {12'h0, u_ram.base_r}, 32'h0);
    cyc(0, UNCONFIGURE, 20'h70500, 4'h0);
    check("unc2_daisy", {31'h0, dout[0]}, 32'h0);
    check("unc2_err", {31'h0, err[0]}, 32'h0);
    cyc(0, LOAD_DP, 20'h70010, 4'h0);
    cyc(0, DP_READ, 20'h0, 4'h0);
    check("unc_rd_act", {31'h0, act_pre}, 32'h0);

    // Pointer wrap
    cyc(0, LOAD_PC, 20'hFFFFF, 4'h0);
    cyc(0, PC_READ, 20'h0, 4'h0);
    check("pc_wrap", {12'h0, u_ram.pc_ptr_r}, 32'h0);

    // Undefined command, error survives BUSCMD_RESET
    cyc(0, UNDEFINED, 20'h0, 4'h0);
    check("undef_err", {31'h0, err[0]}, 32'h1);
    cyc(0, BUS_RESET, 20'h0, 4'h0);
    check("busrst_err", {31'h0, err[0]}, 32'h1);

    // Reset clears error and aborts a half-done configure
    reset = 1'b1;
    cyc(0, NOP, 20'h0, 4'h0);
    reset = 1'b0;
    check("rst2_err", {31'h0, err[0]}, 32'h0);
    cyc(0, CONFIGURE, 20'hFF000, 4'h0);
    reset = 1'b1;
    cyc(0, CONFIGURE, 20'h70000, 4'h0);
    reset = 1'b0;
    check("rstpri_daisy", {31'h0, dout[0]}, 32'h0);
    check("rstpri_base", {12'h0, u_ram.base_r}, 32'h0);
    check("rstpri_len", {11'h0, u_ram.length_r}, 32'h0);

    // Full-space window: address 0 gives length 0x100000
    cyc(0, CONFIGURE, 20'h00000, 4'h0);
    check("full_len", {11'h0, u_ram.length_r}, 32'h100000);
    check("full_len_daisy", {31'h0, dout[0]}, 32'h0);
    cyc(0, CONFIGURE, 20'h00000, 4'h0);
    check("full_daisy", {31'h0, dout[0]}, 32'h1);
    cyc(0, LOAD_DP, 20'hFFFFF, 4'h0);
    cyc(0, DP_WRITE, 20'h0, 4'h6);
    check("full_top_act", {31'h0, act_pre}, 32'h1);
    check("full_dp_wrap", {12'h0, u_ram.dp_ptr_r}, 32'h0);
    cyc(0, DP_READ, 20'h0, 4'h0);
    check("full_bot_act", {31'h0, act_pre}, 32'h1);
    cyc(0, BUS_RESET, 20'h0, 4'h0);
    check("busrst_daisy", {31'h0, dout[0]}, 32'h0);
    check("busrst_len", {11'h0, u_ram.length_r}, 32'h0);
    check("busrst_dp_kept", {12'h0, u_ram.dp_ptr_r}, 32'h1);

    // Mirroring with a 16-nibble array behind a 0x100 window
    cyc(1, CONFIGURE, 20'hFFF00, 4'h0);
    check("mir_len", {11'h0, u_mirror.length_r}, 32'h100);
    cyc(1, CONFIGURE, 20'h80000, 4'h0);
    check("mir_daisy", {31'h0, dout[1]}, 32'h1);
    cyc(1, LOAD_DP, 20'h80003, 4'h0);
    cyc(1, DP_WRITE, 20'h0, 4'h5);
    cyc(1, LOAD_DP, 20'h80013, 4'h0);
    cyc(1, DP_READ, 20'h0, 4'h0);
    check("mir_act", {31'h0, act_pre}, 32'h1);
    check("mir_rd", {28'h0, nout[1]}, 32'h5);

    // Read-only instance: hit write is dropped and flagged
    cyc(2, CONFIGURE, 20'hFF000, 4'h0);
    cyc(2, CONFIGURE, 20'h70000, 4'h0);
    cyc(2, LOAD_PC, 20'h70020, 4'h0);
    cyc(2, PC_READ, 20'h0, 4'h0);
    old_nib = nout[2];
    check("ro_err_before", {31'h0, err[2]}, 32'h0);
    cyc(2, LOAD_PC, 20'h70020, 4'h0);
    cyc(2, PC_WRITE, 20'h0, 4'h7);
    check("ro_wr_act", {31'h0, act_pre}, 32'h1);
    check("ro_err", {31'h0, err[2]}, 32'h1);
    cyc(2, LOAD_PC, 20'h70020, 4'h0);
    cyc(2, PC_READ, 20'h0, 4'h0);
    check("ro_rd_old", {28'h0, nout[2]}, {28'h0, old_nib});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
